issue_data_pipe: RTL and testbench
==================================

ISSUE_DATA_PIPE -- requirements
Module: issue_data_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 64, operand/immediate data width.
REQ-002 SHALL have parameter ROB_W, default 8, robIdx value width; robIdx is {flag, value}.
REQ-003 SHALL have port clock, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports io_enq_valid in 1 and io_enq_ready out 1, the upstream handshake from the immediate-extract stage.
REQ-006 SHALL have ports io_enq_data_0/1/2, input, DATA_W each, extracted source operands.
REQ-007 SHALL have ports io_enq_robIdx_flag in 1 and io_enq_robIdx_value in ROB_W, the entry age.
REQ-008 SHALL have ports io_deq_valid out 1 and io_deq_ready in 1, the handshake to the execution unit.
REQ-009 SHALL have ports io_deq_data_0/1/2 out DATA_W, io_deq_robIdx_flag out 1 and io_deq_robIdx_value out ROB_W.
REQ-010 SHALL have ports io_redirect_valid in 1, io_redirect_robIdx_flag in 1, io_redirect_robIdx_value in ROB_W and io_redirect_level in 1 (1 = flush the redirecting instruction itself).

Function
REQ-011 SHALL hold 2 entries as an in-order FIFO (skid buffer); head drives io_deq_*.
REQ-012 SHALL assert io_enq_ready iff occupancy < 2 from registered state only, with no combinational path from io_deq_ready.
REQ-013 SHALL write an entry on enq fire (valid & ready) and remove the head on deq fire; data appears on io_deq_* the cycle after enq (1-cycle latency).
REQ-014 SHALL keep occupancy unchanged when enq and deq fire in the same cycle with occupancy 1; the new entry becomes head.
REQ-015 SHALL drive io_deq_valid from registered head-valid only; a redirect does not mask io_deq_valid in its own cycle.
REQ-016 SHALL define "killed" for an entry as redirect_valid & (isAfter(entry, redirect) | (level & entry == redirect)), where isAfter(a,b) = (a.flag ^ b.flag) ^ (a.value > b.value).
REQ-017 SHALL invalidate all killed resident entries at the clock edge ending the redirect cycle; a head that deq-fires in that cycle leaves normally and is not counted as killed.
REQ-018 SHALL not store a killed incoming entry; io_enq_ready is unaffected by the redirect.
REQ-019 SHALL compact after a kill: if only the tail is killed, occupancy drops to 1 with the head retained; if the head is killed, the younger tail is killed too and occupancy becomes 0.
REQ-020 SHALL not alter io_deq_data_* while io_deq_valid & !io_deq_ready (stable hold).

Reset
REQ-021 SHALL on reset low clear occupancy to 0 and drive io_deq_valid=0, io_enq_ready=1, io_deq_data_*=0 and io_deq_robIdx_*=0.
REQ-022 SHALL discard all entries, including any in-flight handshake, if reset asserts mid-operation.

Configuration
REQ-023 SHALL, when ISSUE_DATA_PIPE_PERF_EN is defined, add outputs io_perf_flushCnt (16b, +1 per entry killed or enq dropped) and io_perf_stallCnt (16b, +1 per cycle io_deq_valid & !io_deq_ready), both saturating and reset to 0.
REQ-024 SHALL, without ISSUE_DATA_PIPE_PERF_EN, omit those ports and counters; all other behaviour is identical.

Structure
REQ-025 SHALL place the robIdx struct typedef, the isAfter/needFlush functions and the DATA_W/ROB_W defaults in the shared package issue_pkg.
REQ-026 SHALL implement the kill comparison in one sub-module rob_flush_check, instantiated once per entry plus once for enq.

Verification
REQ-027 SHALL check: after reset, enq {data_0=0x1234, robIdx 0/5} with deq_ready=1 -> deq_valid=1 next cycle with data_0=0x1234.
REQ-028 SHALL check: deq_ready=0 with 2 enqs -> enq_ready=0; a third enq is not taken; deq then yields entries in order.
REQ-029 SHALL check: entries robIdx 0/3 and 0/7, redirect 0/5 with level=0 -> only 0/3 remains, occupancy 1.
REQ-030 SHALL check: redirect 0/3 with level=1 and head 0/3 -> both entries killed, deq_valid=0 next cycle.
REQ-031 SHALL check wrap: entry robIdx 1/2, redirect 0/250 -> entry killed (flag differs, younger).
REQ-032 SHALL check: reset asserted with 2 entries -> deq_valid=0 and enq_ready=1 immediately; with PERF_EN, a stall of 5 cycles gives stallCnt=5.

Source files
------------

// File: rtl/issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : issue_pkg
//  Description : Shared types, defaults and robIdx age helpers for the
//                issue data pipe (robIdx struct, isAfter, needFlush).
//  Revision    : 1.0  initial release
// ============================================================================
package issue_pkg;

    localparam int DATA_W_DEF  = 64;
    localparam int ROB_W_DEF   = 8;
    // robIdx values are zero-extended to this width before comparing, so any
    // module-level ROB_W up to this value shares the same struct and helpers.
    localparam int ROB_W_MAX   = 32;
    localparam int NUM_ENTRIES = 2;
    localparam int NUM_SRC     = 3;

    typedef struct packed {
        logic                 flag;
        logic [ROB_W_MAX-1:0] value;
    } rob_idx_t;

    // a is younger than b: the flag toggles on every ROB wrap, so a flag
    // mismatch inverts the meaning of the plain value comparison.
    function automatic logic isAfter(input rob_idx_t a, input rob_idx_t b);
        return (a.flag ^ b.flag) ^ (a.value > b.value);
    endfunction

    // An entry dies on a redirect when it is younger than the redirecting
    // instruction, or is that instruction itself and level asks for it.
    function automatic logic needFlush(input rob_idx_t entry,
                                       input rob_idx_t redirect,
                                       input logic     valid,
                                       input logic     level);
        return valid & (isAfter(entry, redirect) | (level & (entry == redirect)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_flush_check.sv
`default_nettype none
// ============================================================================
//  Module      : rob_flush_check
//  Description : Kill decision for one robIdx against the current redirect.
//  Revision    : 1.0  initial release
// ============================================================================
module rob_flush_check
    import issue_pkg::*;
#(
    parameter int ROB_W = ROB_W_DEF
) (
    input  logic             i_entry_flag,
    input  logic [ROB_W-1:0] i_entry_value,
    input  logic             i_redirect_valid,
    input  logic             i_redirect_flag,
    input  logic [ROB_W-1:0] i_redirect_value,
    input  logic             i_redirect_level,
    output logic             o_kill
);

    rob_idx_t w_entry;
    rob_idx_t w_redirect;

    // Widen both indices into the shared struct and evaluate the kill rule.
    always_comb begin
        w_entry.flag     = i_entry_flag;
        w_entry.value    = ROB_W_MAX'(i_entry_value);
        w_redirect.flag  = i_redirect_flag;
        w_redirect.value = ROB_W_MAX'(i_redirect_value);
        o_kill           = needFlush(w_entry, w_redirect, i_redirect_valid, i_redirect_level);
    end

endmodule
`default_nettype wire

// File: rtl/issue_data_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : issue_data_pipe
//  Description : Two-entry in-order skid buffer between immediate extraction
//                and the execution unit, with redirect-based entry killing.
//                Optional feature macro: ISSUE_DATA_PIPE_PERF_EN adds
//                saturating flush and stall performance counters.
//  Revision    : 1.0  initial release
// ============================================================================
module issue_data_pipe
    import issue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ROB_W  = ROB_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_enq_valid,
    output logic              io_enq_ready,
    input  logic [DATA_W-1:0] io_enq_data_0,
    input  logic [DATA_W-1:0] io_enq_data_1,
    input  logic [DATA_W-1:0] io_enq_data_2,
    input  logic              io_enq_robIdx_flag,
    input  logic [ROB_W-1:0]  io_enq_robIdx_value,
    output logic              io_deq_valid,
    input  logic              io_deq_ready,
    output logic [DATA_W-1:0] io_deq_data_0,
    output logic [DATA_W-1:0] io_deq_data_1,
    output logic [DATA_W-1:0] io_deq_data_2,
    output logic              io_deq_robIdx_flag,
    output logic [ROB_W-1:0]  io_deq_robIdx_value,
    input  logic              io_redirect_valid,
    input  logic              io_redirect_robIdx_flag,
    input  logic [ROB_W-1:0]  io_redirect_robIdx_value,
    input  logic              io_redirect_level
`ifdef ISSUE_DATA_PIPE_PERF_EN
    ,
    output logic [15:0]       io_perf_flushCnt,
    output logic [15:0]       io_perf_stallCnt
`endif
);

    // Entry payload layout: {flag, value, data_2, data_1, data_0}
    localparam int PAY_W    = NUM_SRC * DATA_W + ROB_W + 1;
    localparam int VAL_LSB  = NUM_SRC * DATA_W;
    localparam int FLAG_BIT = PAY_W - 1;

    logic [NUM_ENTRIES-1:0][PAY_W-1:0] payload_q;
    logic [NUM_ENTRIES-1:0][PAY_W-1:0] payload_d;
    logic [NUM_ENTRIES-1:0]            valid_q;
    logic [NUM_ENTRIES-1:0]            valid_d;

    logic [NUM_ENTRIES-1:0] w_kill_entry;
    logic                   w_kill_enq;
    logic [PAY_W-1:0]       w_enq_payload;
    logic                   w_deq_fire;
    logic                   w_enq_fire;
    logic                   w_head_kill;
    logic                   w_head_keep;
    logic                   w_tail_keep;
    logic                   w_enq_keep;

    assign w_enq_payload = {io_enq_robIdx_flag, io_enq_robIdx_value,
                            io_enq_data_2, io_enq_data_1, io_enq_data_0};

    // One kill checker per resident entry.
    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry_chk
            rob_flush_check #(
                .ROB_W (ROB_W)
            ) u_chk (
                .i_entry_flag     (payload_q[gi][FLAG_BIT]),
                .i_entry_value    (payload_q[gi][VAL_LSB +: ROB_W]),
                .i_redirect_valid (io_redirect_valid),
                .i_redirect_flag  (io_redirect_robIdx_flag),
                .i_redirect_value (io_redirect_robIdx_value),
                .i_redirect_level (io_redirect_level),
                .o_kill           (w_kill_entry[gi])
            );
        end
    endgenerate

    // Kill checker for the entry arriving this cycle.
    rob_flush_check #(
        .ROB_W (ROB_W)
    ) u_enq_chk (
        .i_entry_flag     (io_enq_robIdx_flag),
        .i_entry_value    (io_enq_robIdx_value),
        .i_redirect_valid (io_redirect_valid),
        .i_redirect_flag  (io_redirect_robIdx_flag),
        .i_redirect_value (io_redirect_robIdx_value),
        .i_redirect_level (io_redirect_level),
        .o_kill           (w_kill_enq)
    );

    // Ready and valid come straight from flops; no path from io_deq_ready.
    assign io_enq_ready        = ~valid_q[1];
    assign io_deq_valid        = valid_q[0];
    assign io_deq_data_0       = payload_q[0][0 +: DATA_W];
    assign io_deq_data_1       = payload_q[0][DATA_W +: DATA_W];
    assign io_deq_data_2       = payload_q[0][2*DATA_W +: DATA_W];
    assign io_deq_robIdx_value = payload_q[0][VAL_LSB +: ROB_W];
    assign io_deq_robIdx_flag  = payload_q[0][FLAG_BIT];

    // Classify each candidate (head, tail, incoming) as surviving or not.
    // A killed head implies the younger tail dies with it.
    always_comb begin
        w_deq_fire  = valid_q[0] & io_deq_ready;
        w_enq_fire  = io_enq_valid & ~valid_q[1];
        w_head_kill = valid_q[0] & ~w_deq_fire & w_kill_entry[0];
        w_head_keep = valid_q[0] & ~w_deq_fire & ~w_kill_entry[0];
        w_tail_keep = valid_q[1] & ~w_kill_entry[1] & ~w_head_kill;
        w_enq_keep  = w_enq_fire & ~w_kill_enq;
    end

    // Compact survivors in age order into slot 0 then slot 1.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;

        valid_d[0] = w_head_keep | w_tail_keep | w_enq_keep;
        if (!w_head_keep) begin
            if (w_tail_keep) begin
                payload_d[0] = payload_q[1];
            end else if (w_enq_keep) begin
                payload_d[0] = w_enq_payload;
            end
        end

        valid_d[1] = (w_head_keep & w_tail_keep) |
                     ((w_head_keep | w_tail_keep) & w_enq_keep);
        if (!(w_head_keep & w_tail_keep) && (w_head_keep | w_tail_keep) && w_enq_keep) begin
            payload_d[1] = w_enq_payload;
        end
    end

    // Entry storage; reset discards everything including in-flight writes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q   <= '0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

`ifdef ISSUE_DATA_PIPE_PERF_EN
    logic [15:0] flush_cnt_q;
    logic [15:0] flush_cnt_d;
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;
    logic [1:0]  w_flush_inc;
    logic [16:0] w_flush_sum;
    logic        w_tail_kill;
    logic        w_enq_drop;

    // Saturating counters: entries lost to redirects and cycles stalled.
    always_comb begin
        w_tail_kill = valid_q[1] & ~w_tail_keep;
        w_enq_drop  = w_enq_fire & w_kill_enq;
        w_flush_inc = 2'(w_head_kill) + 2'(w_tail_kill) + 2'(w_enq_drop);
        w_flush_sum = {1'b0, flush_cnt_q} + 17'(w_flush_inc);
        flush_cnt_d = w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
        stall_cnt_d = stall_cnt_q;
        if (valid_q[0] && !io_deq_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign io_perf_flushCnt = flush_cnt_q;
    assign io_perf_stallCnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_data_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_issue_data_pipe
//  Description : Self-checking bench for issue_data_pipe: directed scenarios
//                plus randomized traffic against a queue-based model.
//                Honours ISSUE_DATA_PIPE_PERF_EN for the counter checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_issue_data_pipe;

    localparam int DATA_W = 64;
    localparam int ROB_W  = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              io_enq_valid, io_enq_ready;
    logic [DATA_W-1:0] io_enq_data_0, io_enq_data_1, io_enq_data_2;
    logic              io_enq_robIdx_flag;
    logic [ROB_W-1:0]  io_enq_robIdx_value;
    logic              io_deq_valid, io_deq_ready;
    logic [DATA_W-1:0] io_deq_data_0, io_deq_data_1, io_deq_data_2;
    logic              io_deq_robIdx_flag;
    logic [ROB_W-1:0]  io_deq_robIdx_value;
    logic              io_redirect_valid, io_redirect_robIdx_flag, io_redirect_level;
    logic [ROB_W-1:0]  io_redirect_robIdx_value;
`ifdef ISSUE_DATA_PIPE_PERF_EN
    logic [15:0]       io_perf_flushCnt, io_perf_stallCnt;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        logic              flag;
        logic [ROB_W-1:0]  value;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_flush;
    int unsigned m_stall;

    issue_data_pipe #(.DATA_W(DATA_W), .ROB_W(ROB_W)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .io_enq_valid             (io_enq_valid),
        .io_enq_ready             (io_enq_ready),
        .io_enq_data_0            (io_enq_data_0),
        .io_enq_data_1            (io_enq_data_1),
        .io_enq_data_2            (io_enq_data_2),
        .io_enq_robIdx_flag       (io_enq_robIdx_flag),
        .io_enq_robIdx_value      (io_enq_robIdx_value),
        .io_deq_valid             (io_deq_valid),
        .io_deq_ready             (io_deq_ready),
        .io_deq_data_0            (io_deq_data_0),
        .io_deq_data_1            (io_deq_data_1),
        .io_deq_data_2            (io_deq_data_2),
        .io_deq_robIdx_flag       (io_deq_robIdx_flag),
        .io_deq_robIdx_value      (io_deq_robIdx_value),
        .io_redirect_valid        (io_redirect_valid),
        .io_redirect_robIdx_flag  (io_redirect_robIdx_flag),
        .io_redirect_robIdx_value (io_redirect_robIdx_value),
        .io_redirect_level        (io_redirect_level)
`ifdef ISSUE_DATA_PIPE_PERF_EN
        ,
        .io_perf_flushCnt         (io_perf_flushCnt),
        .io_perf_stallCnt         (io_perf_stallCnt)
`endif
    );

    always #5 clock = ~clock;

    // Entry a is dead if it is younger than redirect r (ROB wrap aware), or
    // equal to it with level set.
    function automatic bit tb_killed(bit ef, bit [ROB_W-1:0] ev, bit rf, bit [ROB_W-1:0] rv, bit lvl);
        bit younger;
        if (ef != rf) younger = (ev <= rv);
        else          younger = (ev > rv);
        return younger || (lvl && ef == rf && ev == rv);
    endfunction

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        io_enq_valid = 0; io_enq_data_0 = '0; io_enq_data_1 = '0; io_enq_data_2 = '0;
        io_enq_robIdx_flag = 0; io_enq_robIdx_value = '0; io_deq_ready = 0;
        io_redirect_valid = 0; io_redirect_robIdx_flag = 0;
        io_redirect_robIdx_value = '0; io_redirect_level = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 0;
        repeat (2) @(negedge clock);
        reset = 1;
    endtask

    task automatic put(input bit f, input bit [ROB_W-1:0] v, input bit [DATA_W-1:0] d);
        io_enq_valid = 1; io_enq_robIdx_flag = f; io_enq_robIdx_value = v;
        io_enq_data_0 = d; io_enq_data_1 = ~d; io_enq_data_2 = d + 64'd1;
    endtask

    task automatic redirect(input bit f, input bit [ROB_W-1:0] v, input bit lvl);
        io_redirect_valid = 1; io_redirect_robIdx_flag = f;
        io_redirect_robIdx_value = v; io_redirect_level = lvl;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        @(negedge clock); #1;
        total++; if (io_deq_valid !== 1'b0) begin bad++; $display("FAIL reset_deq_valid got=%0b exp=0", io_deq_valid); end
        total++; if (io_enq_ready !== 1'b1) begin bad++; $display("FAIL reset_enq_ready got=%0b exp=1", io_enq_ready); end
        total++; if ({io_deq_data_0, io_deq_data_1, io_deq_data_2} !== '0) begin bad++; $display("FAIL reset_deq_data got=%0h exp=0", {io_deq_data_0, io_deq_data_1, io_deq_data_2}); end
        total++; if ({io_deq_robIdx_flag, io_deq_robIdx_value} !== 9'd0) begin bad++; $display("FAIL reset_robidx got=%0h exp=0", {io_deq_robIdx_flag, io_deq_robIdx_value}); end
        @(negedge clock);
        reset = 1;
    endtask

    task automatic test_basic();
        apply_reset();
        io_deq_ready = 1;
        put(0, 8'd5, 64'h1234);
        cyc();
        io_enq_valid = 0;
        total++; if (io_deq_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", io_deq_valid); end
        total++; if (io_deq_data_0 !== 64'h1234) begin bad++; $display("FAIL basic_data0 got=%0h exp=1234", io_deq_data_0); end
        total++; if ({io_deq_robIdx_flag, io_deq_robIdx_value} !== {1'b0, 8'd5}) begin bad++; $display("FAIL basic_robidx got=%0h exp=5", {io_deq_robIdx_flag, io_deq_robIdx_value}); end
        cyc();
        total++; if (io_deq_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%0b exp=0", io_deq_valid); end
    endtask

    task automatic test_full();
        apply_reset();
        put(0, 8'd10, 64'hA); cyc();
        put(0, 8'd11, 64'hB); cyc();
        total++; if (io_enq_ready !== 1'b0) begin bad++; $display("FAIL full_enq_ready got=%0b exp=0", io_enq_ready); end
        put(0, 8'd12, 64'hC); cyc();
        io_enq_valid = 0;
        total++; if (io_deq_data_0 !== 64'hA) begin bad++; $display("FAIL full_hold got=%0h exp=a", io_deq_data_0); end
        io_deq_ready = 1;
        cyc();
        total++; if (io_deq_valid !== 1'b1 || io_deq_data_0 !== 64'hB) begin bad++; $display("FAIL full_second got=%0b/%0h exp=1/b", io_deq_valid, io_deq_data_0); end
        cyc();
        total++; if (io_deq_valid !== 1'b0) begin bad++; $display("FAIL full_third_dropped got=%0b exp=0", io_deq_valid); end
    endtask

    task automatic test_redirect_tail();
        apply_reset();
        put(0, 8'd3, 64'h33); cyc();
        put(0, 8'd7, 64'h77); cyc();
        io_enq_valid = 0;
        redirect(0, 8'd5, 0);
        #1;
        total++; if (io_deq_valid !== 1'b1) begin bad++; $display("FAIL redir_not_masked got=%0b exp=1", io_deq_valid); end
        cyc();
        io_redirect_valid = 0;
        total++; if (io_deq_valid !== 1'b1 || io_deq_robIdx_value !== 8'd3 || io_deq_data_0 !== 64'h33) begin bad++; $display("FAIL redir_head_kept got=%0b/%0h exp=1/3", io_deq_valid, io_deq_robIdx_value); end
        total++; if (io_enq_ready !== 1'b1) begin bad++; $display("FAIL redir_occ1_ready got=%0b exp=1", io_enq_ready); end
        io_deq_ready = 1;
        cyc();
        total++; if (io_deq_valid !== 1'b0) begin bad++; $display("FAIL redir_occ1_empty got=%0b exp=0", io_deq_valid); end
    endtask

    task automatic test_redirect_level();
        apply_reset();
        put(0, 8'd3, 64'h33); cyc();
        put(0, 8'd4, 64'h44); cyc();
        io_enq_valid = 0;
        redirect(0, 8'd3, 1);
        cyc();
        io_redirect_valid = 0;
        total++; if (io_deq_valid !== 1'b0) begin bad++; $display("FAIL level_kill_valid got=%0b exp=0", io_deq_valid); end
        total++; if (io_enq_ready !== 1'b1) begin bad++; $display("FAIL level_kill_ready got=%0b exp=1", io_enq_ready); end
    endtask

    task automatic test_wrap();
        apply_reset();
        put(1, 8'd2, 64'h12); cyc();
        put(1, 8'd3, 64'h13);
        redirect(0, 8'd250, 0);
        #1;
        total++; if (io_enq_ready !== 1'b1) begin bad++; $display("FAIL wrap_enq_ready got=%0b exp=1", io_enq_ready); end
        cyc();
        idle_inputs();
        total++; if (io_deq_valid !== 1'b0) begin bad++; $display("FAIL wrap_kill got=%0b exp=0", io_deq_valid); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        put(0, 8'd20, 64'h20); cyc();
        put(0, 8'd21, 64'h21); cyc();
        put(0, 8'd22, 64'h22);
        reset = 0;
        #1;
        total++; if (io_deq_valid !== 1'b0 || io_enq_ready !== 1'b1) begin bad++; $display("FAIL midreset_async got=%0b/%0b exp=0/1", io_deq_valid, io_enq_ready); end
        total++; if (io_deq_data_0 !== 64'h0) begin bad++; $display("FAIL midreset_data got=%0h exp=0", io_deq_data_0); end
        @(negedge clock);
        io_enq_valid = 0;
        reset = 1;
        cyc();
        total++; if (io_deq_valid !== 1'b0) begin bad++; $display("FAIL midreset_empty got=%0b exp=0", io_deq_valid); end
`ifdef ISSUE_DATA_PIPE_PERF_EN
        put(0, 8'd30, 64'h30); cyc();
        io_enq_valid = 0;
        repeat (5) cyc();
        total++; if (io_perf_stallCnt !== 16'd5) begin bad++; $display("FAIL perf_stall5 got=%0d exp=5", io_perf_stallCnt); end
`endif
    endtask

    task automatic test_random();
        ent_t        nq[$];
        ent_t        e;
        logic [8:0]  ptr;
        logic [8:0]  rp;
        int          sz;
        bit          dfire, efire, gone;
        apply_reset();
        mq.delete();
        m_flush = 0;
        m_stall = 0;
        ptr = '0;
        for (int n = 0; n < 3000; n++) begin
            total++; if (io_deq_valid !== (mq.size() > 0)) begin bad++; $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, io_deq_valid, mq.size() > 0); end
            total++; if (io_enq_ready !== (mq.size() < 2)) begin bad++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, io_enq_ready, mq.size() < 2); end
            if (mq.size() > 0) begin
                total++;
                if ({io_deq_data_0, io_deq_data_1, io_deq_data_2, io_deq_robIdx_flag, io_deq_robIdx_value} !== mq[0]) begin
                    bad++;
                    $display("FAIL rnd_head n=%0d got=%0h/%0h exp=%0h/%0h", n, io_deq_robIdx_value, io_deq_data_0, mq[0].value, mq[0].d0);
                end
            end
            io_enq_valid        = ($urandom_range(0, 3) != 0);
            io_enq_data_0       = {$urandom, $urandom};
            io_enq_data_1       = {$urandom, $urandom};
            io_enq_data_2       = {$urandom, $urandom};
            io_enq_robIdx_flag  = ptr[8];
            io_enq_robIdx_value = ptr[7:0];
            if (io_enq_valid) ptr = ptr + 9'($urandom_range(1, 2));
            io_deq_ready        = ($urandom_range(0, 2) != 0);
            io_redirect_valid   = ($urandom_range(0, 7) == 0);
            rp                  = ptr - 9'($urandom_range(0, 5));
            io_redirect_robIdx_flag  = rp[8];
            io_redirect_robIdx_value = rp[7:0];
            io_redirect_level   = 1'($urandom_range(0, 1));

            sz    = mq.size();
            dfire = (sz > 0) && io_deq_ready;
            efire = io_enq_valid && (sz < 2);
            gone  = 0;
            nq.delete();
            if (sz > 0 && !io_deq_ready) m_stall++;
            for (int i = 0; i < sz; i++) begin
                if (i == 0 && dfire) continue;
                if (gone || (io_redirect_valid && tb_killed(mq[i].flag, mq[i].value, rp[8], rp[7:0], io_redirect_level))) begin
                    m_flush++;
                    if (i == 0) gone = 1;
                    continue;
                end
                nq.push_back(mq[i]);
            end
            if (efire) begin
                e = {io_enq_data_0, io_enq_data_1, io_enq_data_2, io_enq_robIdx_flag, io_enq_robIdx_value};
                if (io_redirect_valid && tb_killed(e.flag, e.value, rp[8], rp[7:0], io_redirect_level)) m_flush++;
                else nq.push_back(e);
            end
            cyc();
            mq = nq;
        end
        idle_inputs();
`ifdef ISSUE_DATA_PIPE_PERF_EN
        total++; if (io_perf_flushCnt !== 16'(m_flush)) begin bad++; $display("FAIL rnd_flushcnt got=%0d exp=%0d", io_perf_flushCnt, m_flush); end
        total++; if (io_perf_stallCnt !== 16'(m_stall)) begin bad++; $display("FAIL rnd_stallcnt got=%0d exp=%0d", io_perf_stallCnt, m_stall); end
`endif
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        test_reset();
        test_basic();
        test_full();
        test_redirect_tail();
        test_redirect_level();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
